// File: rtl/operand_reader_if.sv
// -----------------------------------------------------------------------------
// operand_reader_if
// Bundles the signals exchanged between the operand-read stage and its
// neighbours:
//   - decode side   : IN_VALID/IN_READY handshake, source/destination indices
//                     and their use flags
//   - execute side  : OUT_VALID/OUT_READY handshake, registered operands,
//                     forwarded destination index and write flag
//   - writeback side: WB_ENABLE/WB_RD/WB_DATA, the register-file write port
//   - FLUSH         : discards the bundle held toward execute
// Modports:
//   master - the environment (decode, execute, writeback, branch unit)
//   slave  - the operand_reader block itself
// -----------------------------------------------------------------------------
interface operand_reader_if #(
    parameter int XLEN = 32,
    parameter int IW   = 5
);
    // Decode -> operand reader
    logic            IN_VALID;
    logic            IN_READY;
    logic [IW-1:0]   IN_RS1;
    logic [IW-1:0]   IN_RS2;
    logic            IN_USE_RS1;
    logic            IN_USE_RS2;
    logic [IW-1:0]   IN_RD;
    logic            IN_WRITES_RD;

    // Operand reader -> execute
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] OUT_RS1_DATA;
    logic [XLEN-1:0] OUT_RS2_DATA;
    logic [IW-1:0]   OUT_RD;
    logic            OUT_WRITES_RD;

    // Writeback -> register file write port
    logic            WB_ENABLE;
    logic [IW-1:0]   WB_RD;
    logic [XLEN-1:0] WB_DATA;

    // Pipeline flush
    logic            FLUSH;

    modport master (
        output IN_VALID, IN_RS1, IN_RS2, IN_USE_RS1, IN_USE_RS2, IN_RD, IN_WRITES_RD,
        input  IN_READY,
        input  OUT_VALID, OUT_RS1_DATA, OUT_RS2_DATA, OUT_RD, OUT_WRITES_RD,
        output OUT_READY,
        output WB_ENABLE, WB_RD, WB_DATA,
        output FLUSH
    );

    modport slave (
        input  IN_VALID, IN_RS1, IN_RS2, IN_USE_RS1, IN_USE_RS2, IN_RD, IN_WRITES_RD,
        output IN_READY,
        output OUT_VALID, OUT_RS1_DATA, OUT_RS2_DATA, OUT_RD, OUT_WRITES_RD,
        input  OUT_READY,
        input  WB_ENABLE, WB_RD, WB_DATA,
        input  FLUSH
    );
endinterface

// File: rtl/operand_reader.sv
// -----------------------------------------------------------------------------
// operand_reader
// Register-read stage of the integer pipeline.
//   - Owns the NREG x XLEN integer register file; its single write port is
//     driven by writeback (WB_*). x0 is hardwired to zero.
//   - Accepts decoded instructions, reads rs1/rs2 with a same-cycle bypass
//     from the writeback port, and keeps a pending-write scoreboard so that
//     RAW and WAW hazards stall the instruction at the input.
//   - Presents a registered operand bundle to execute over OUT_VALID/OUT_READY.
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RSTN - synchronous active-low reset
//   bus  - operand_reader_if.slave (decode, execute, writeback, FLUSH)
// -----------------------------------------------------------------------------
module operand_reader #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    operand_reader_if.slave   bus
);
    localparam int IW = $clog2(NREG);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    logic            out_valid_q,     out_valid_d;
    logic [XLEN-1:0] out_rs1_data_q,  out_rs1_data_d;
    logic [XLEN-1:0] out_rs2_data_q,  out_rs2_data_d;
    logic [IW-1:0]   out_rd_q,        out_rd_d;
    logic            out_writes_rd_q, out_writes_rd_d;

    // -------------------------------------------------------------------------
    // Writeback hits: the writeback port is about to deliver the value an
    // incoming instruction needs, so the scoreboard bit for that index no
    // longer blocks it and the operand comes straight from WB_DATA.
    // -------------------------------------------------------------------------
    logic wb_hit_rs1;
    logic wb_hit_rs2;
    logic wb_hit_rd;

    assign wb_hit_rs1 = bus.WB_ENABLE && (bus.WB_RD == bus.IN_RS1) && (bus.IN_RS1 != '0);
    assign wb_hit_rs2 = bus.WB_ENABLE && (bus.WB_RD == bus.IN_RS2) && (bus.IN_RS2 != '0);
    assign wb_hit_rd  = bus.WB_ENABLE && (bus.WB_RD == bus.IN_RD)  && (bus.IN_RD  != '0);

    // -------------------------------------------------------------------------
    // Hazard and accept
    // -------------------------------------------------------------------------
    logic hazard;
    logic slot_free;
    logic in_ready;
    logic accept;

    assign hazard = (bus.IN_USE_RS1   && pend_q[bus.IN_RS1] && !wb_hit_rs1)
                  | (bus.IN_USE_RS2   && pend_q[bus.IN_RS2] && !wb_hit_rs2)
                  | (bus.IN_WRITES_RD && pend_q[bus.IN_RD]  && !wb_hit_rd);

    // The output register can take a new bundle if it is empty or is being
    // consumed by execute in this same cycle.
    assign slot_free = !out_valid_q || bus.OUT_READY;
    assign in_ready  = RSTN && !bus.FLUSH && !hazard && slot_free;
    assign accept    = bus.IN_VALID && in_ready;

    // -------------------------------------------------------------------------
    // Operand read with writeback bypass
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] rs1_operand;
    logic [XLEN-1:0] rs2_operand;

    always_comb begin
        rs1_operand = '0;
        if (wb_hit_rs1) begin
            rs1_operand = bus.WB_DATA;
        end else if (bus.IN_RS1 != '0) begin
            rs1_operand = regs_q[bus.IN_RS1];
        end
    end

    always_comb begin
        rs2_operand = '0;
        if (wb_hit_rs2) begin
            rs2_operand = bus.WB_DATA;
        end else if (bus.IN_RS2 != '0) begin
            rs2_operand = regs_q[bus.IN_RS2];
        end
    end

    // -------------------------------------------------------------------------
    // Flushing a held bundle that would have written rd: that write will now
    // never reach writeback, so its scoreboard bit must be released here.
    // When writeback targets the same index in the same cycle, the writeback
    // clear already covers it.
    // -------------------------------------------------------------------------
    logic flush_drop;

    assign flush_drop = bus.FLUSH && out_valid_q && out_writes_rd_q
                     && !(bus.WB_ENABLE && (bus.WB_RD == out_rd_q));

    // -------------------------------------------------------------------------
    // Register file and scoreboard next state, one slice per register.
    // Entry 0 is tied off so x0 reads zero and never appears pending.
    // -------------------------------------------------------------------------
    assign regs_d[0] = '0;
    assign pend_d[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_entry
            logic wb_sel;
            logic set_hit;
            logic flush_clr;

            assign wb_sel    = bus.WB_ENABLE && (bus.WB_RD == IW'(gi));
            assign set_hit   = accept && bus.IN_WRITES_RD && (bus.IN_RD == IW'(gi));
            assign flush_clr = flush_drop && (out_rd_q == IW'(gi));

            assign regs_d[gi] = wb_sel ? bus.WB_DATA : regs_q[gi];

            // A new producer accepted in the same cycle as the previous
            // producer's writeback keeps the bit set.
            assign pend_d[gi] = set_hit || (pend_q[gi] && !wb_sel && !flush_clr);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output bundle next state
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d     = out_valid_q;
        out_rs1_data_d  = out_rs1_data_q;
        out_rs2_data_d  = out_rs2_data_q;
        out_rd_d        = out_rd_q;
        out_writes_rd_d = out_writes_rd_q;

        if (accept) begin
            out_valid_d     = 1'b1;
            out_rs1_data_d  = rs1_operand;
            out_rs2_data_d  = rs2_operand;
            out_rd_d        = bus.IN_RD;
            out_writes_rd_d = bus.IN_WRITES_RD;
        end else if (bus.FLUSH || bus.OUT_READY) begin
            // Only the valid bit drops; the data fields keep their last value.
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q          <= '0;
            out_valid_q     <= 1'b0;
            out_rs1_data_q  <= '0;
            out_rs2_data_q  <= '0;
            out_rd_q        <= '0;
            out_writes_rd_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q          <= pend_d;
            out_valid_q     <= out_valid_d;
            out_rs1_data_q  <= out_rs1_data_d;
            out_rs2_data_q  <= out_rs2_data_d;
            out_rd_q        <= out_rd_d;
            out_writes_rd_q <= out_writes_rd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.IN_READY      = in_ready;
    assign bus.OUT_VALID     = out_valid_q;
    assign bus.OUT_RS1_DATA  = out_rs1_data_q;
    assign bus.OUT_RS2_DATA  = out_rs2_data_q;
    assign bus.OUT_RD        = out_rd_q;
    assign bus.OUT_WRITES_RD = out_writes_rd_q;

endmodule

// File: doc/operand_reader.md
Name: operand_reader

Overview:
- Read-side counterpart of the writeback stage. Holds the 32-entry integer register file and its single write port, which is driven by writeback.
- Accepts decoded instructions, reads the rs1/rs2 operands with same-cycle writeback bypass, and tracks pending destination writes in a scoreboard to stall RAW and WAW hazards.
- Delivers registered operands to the execute stage over a valid/ready handshake.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREG, 32, number of architectural registers. Index width is log2(NREG). x0 is hardwired to zero.

Ports:
- CLK  input  1  clock. All state updates on rising edge.
- RSTN  input  1  synchronous active-low reset, sampled on rising edge of CLK.
- IN_VALID  input  1  decoded instruction present.
- IN_READY  output  1  block accepts the instruction this cycle.
- IN_RS1  input  5  source register 1 index.
- IN_RS2  input  5  source register 2 index.
- IN_USE_RS1  input  1  instruction reads rs1.
- IN_USE_RS2  input  1  instruction reads rs2.
- IN_RD  input  5  destination index.
- IN_WRITES_RD  input  1  instruction will write rd at writeback.
- OUT_VALID  output  1  operand bundle valid toward execute.
- OUT_READY  input  1  execute consumes the bundle.
- OUT_RS1_DATA  output  XLEN  operand 1.
- OUT_RS2_DATA  output  XLEN  operand 2.
- OUT_RD  output  5  forwarded destination index.
- OUT_WRITES_RD  output  1  forwarded write flag.
- WB_ENABLE  input  1  writeback write enable.
- WB_RD  input  5  writeback destination.
- WB_DATA  input  XLEN  writeback data.
- FLUSH  input  1  discard the held bundle, e.g. after a taken branch.

Behaviour:
- Reset (RSTN=0 at a clock edge):
  - All registers cleared to 0 and all scoreboard bits cleared.
  - OUT_VALID=0; OUT_RS1_DATA, OUT_RS2_DATA, OUT_RD and OUT_WRITES_RD = 0.
  - IN_READY=0 during the reset cycle.
  - Reset overrides all other inputs, including mid-stall.
- Register write: when WB_ENABLE=1 and WB_RD≠0, regs[WB_RD]<=WB_DATA at the edge. A write with WB_RD=0 is ignored, so x0 always reads 0.
- Scoreboard pend[NREG]:
  - Set on accept when IN_WRITES_RD=1 and IN_RD≠0.
  - Cleared when WB_ENABLE=1 for that index.
  - pend[0] is constant 0.
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard, evaluated combinationally:
  - haz = (IN_USE_RS1 & pend[IN_RS1] & !wbhit1) | (IN_USE_RS2 & pend[IN_RS2] & !wbhit2) | (IN_WRITES_RD & pend[IN_RD] & !wbhitd).
  - wbhitN = WB_ENABLE & WB_RD==index & index≠0.
- Output slot: free = !OUT_VALID | OUT_READY.
- Accept: IN_READY = RSTN & !FLUSH & !haz & free. Accept = IN_VALID & IN_READY.
- Operand read with bypass:
  - If wbhit for the source, the operand is WB_DATA.
  - Else if the index is 0, the operand is 0.
  - Else the operand is regs[index].
- On accept:
  - Bundle registered into the OUT_* registers; OUT_VALID<=1.
  - Latency: 1 cycle from accept to OUT_VALID.
- Without accept:
  - If OUT_READY=1, OUT_VALID<=0.
  - Otherwise the bundle holds with all OUT_* fields stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH=1:
  - OUT_VALID<=0 and no accept that cycle.
  - If the held bundle had OUT_VALID=1 and OUT_WRITES_RD=1, pend[OUT_RD] is cleared, unless WB_ENABLE targets the same index.
  - Instructions already past execute are not affected.
- Back-to-back: one instruction per cycle when there is no hazard and OUT_READY=1.
- Stalled dependent instruction: accepted in the same cycle its producer's WB_ENABLE arrives, using the bypassed data.

Test Plan:
- Reset then read: write x5=0x12345678 via WB, then issue rs1=5, rs2=0 -> OUT_RS1_DATA=0x12345678, OUT_RS2_DATA=0, OUT_VALID=1 one cycle after accept.
- x0 protection: WB_ENABLE with WB_RD=0, WB_DATA=0xFFFFFFFF, then read rs1=0 -> operand 0, pend[0] stays 0.
- RAW stall and bypass: issue rd=3 write, then rs1=3 consumer -> IN_READY=0 until WB_RD=3, WB_DATA=0xA5A5A5A5; in that cycle IN_READY=1 and OUT_RS1_DATA=0xA5A5A5A5 next cycle.
- WAW stall: two instructions both rd=7 -> second held with IN_READY=0 until WB_RD=7 write, then accepted; pend[7]=1 afterwards.
- Backpressure: OUT_READY=0 for 3 cycles with bundle rd=4, rs data 0x11/0x22 -> OUT fields unchanged, IN_READY=0; OUT_READY=1 -> next instruction enters the following cycle.
- Flush mid-stall: bundle rd=9 held, FLUSH=1 -> OUT_VALID=0 next cycle and pend[9]=0; reset asserted mid-stall -> all outputs 0, scoreboard clear.
